// File: rtl/execute_if.sv
// Execute-stage bus: decode/fetch operands in, registered ALU result and live CC out.
// Latency: n/a (signal bundle only).
// Backpressure: none; in_valid is a one-cycle strobe and out_valid follows it one edge later.
// Ports (slave = execute side):
//   in  : in_valid, icode[3:0], ifun[3:0], valA/valB/valC[63:0]
//   out : out_valid, valE[63:0], cnd, ins_err, zf, sf, of
interface execute_if;
  logic        in_valid;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [63:0] valA;
  logic [63:0] valB;
  logic [63:0] valC;
  logic        out_valid;
  logic [63:0] valE;
  logic        cnd;
  logic        ins_err;
  logic        zf;
  logic        sf;
  logic        of;

  modport slave (
    input  in_valid, icode, ifun, valA, valB, valC,
    output out_valid, valE, cnd, ins_err, zf, sf, of
  );

  modport master (
    output in_valid, icode, ifun, valA, valB, valC,
    input  out_valid, valE, cnd, ins_err, zf, sf, of
  );
endinterface

// File: rtl/execute.sv
// SEQ Y86-64 execute stage: ALU for valE, condition-code register, Cnd for cmovXX/jXX.
// Latency: one cycle; results registered on the edge that samples in_valid=1.
// Backpressure: none; always accepts, out_valid drops when in_valid is low (results hold).
// Ports:
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : execute_if.slave (operands in; valE/cnd/ins_err/out_valid registered; zf/sf/of live CC)
module execute #(
  parameter int         STACK_STEP = 8,
  parameter logic [2:0] CC_RESET   = 3'b100
) (
  input  logic      clk,
  input  logic      rst,
  execute_if.slave  bus
);

  // Register state. cc_q is packed {ZF,SF,OF}.
  logic        out_valid_q;
  logic [63:0] valE_q, valE_d;
  logic        cnd_q, cnd_d;
  logic        ins_err_q, ins_err_d;
  logic [2:0]  cc_q, cc_d;

  logic [63:0] sum_ba, diff_ba, step;
  logic        cc_zf, cc_sf, cc_of;
  logic        cond;

  assign step    = 64'(STACK_STEP);
  assign sum_ba  = bus.valB + bus.valA;
  assign diff_ba = bus.valB - bus.valA;

  assign cc_zf = cc_q[2];
  assign cc_sf = cc_q[1];
  assign cc_of = cc_q[0];

  // Branch/move condition evaluated on the CC held before this edge,
  // so an OPq immediately ahead of a jXX is already visible here.
  always_comb begin
    cond = 1'b0;
    case (bus.ifun[2:0])
      3'd0:    cond = 1'b1;
      3'd1:    cond = (cc_sf ^ cc_of) | cc_zf;
      3'd2:    cond = cc_sf ^ cc_of;
      3'd3:    cond = cc_zf;
      3'd4:    cond = ~cc_zf;
      3'd5:    cond = ~(cc_sf ^ cc_of);
      3'd6:    cond = ~(cc_sf ^ cc_of) & ~cc_zf;
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    valE_d    = '0;
    cnd_d     = 1'b0;
    ins_err_d = 1'b0;
    cc_d      = cc_q;
    case (bus.icode)
      4'h2, 4'h7: begin
        if (bus.ifun > 4'd6) begin
          ins_err_d = 1'b1;
        end else begin
          cnd_d = cond;
          // cmovXX forwards valA regardless of the condition; write-back uses cnd.
          if (bus.icode == 4'h2) valE_d = bus.valA;
        end
      end
      4'h3: valE_d = bus.valC;
      4'h4, 4'h5: valE_d = bus.valB + bus.valC;
      4'h6: begin
        case (bus.ifun)
          4'd0: begin
            valE_d = sum_ba;
            cc_d   = {sum_ba == 64'd0, sum_ba[63],
                      (bus.valA[63] == bus.valB[63]) && (sum_ba[63] != bus.valA[63])};
          end
          4'd1: begin
            valE_d = diff_ba;
            cc_d   = {diff_ba == 64'd0, diff_ba[63],
                      (bus.valA[63] != bus.valB[63]) && (diff_ba[63] != bus.valB[63])};
          end
          4'd2: begin
            valE_d = bus.valB & bus.valA;
            cc_d   = {valE_d == 64'd0, valE_d[63], 1'b0};
          end
          4'd3: begin
            valE_d = bus.valB ^ bus.valA;
            cc_d   = {valE_d == 64'd0, valE_d[63], 1'b0};
          end
          default: ins_err_d = 1'b1;
        endcase
      end
      4'h8, 4'hA: valE_d = bus.valB - step;
      4'h9, 4'hB: valE_d = bus.valB + step;
      4'hC, 4'hD, 4'hE, 4'hF: ins_err_d = 1'b1;
      default: valE_d = '0;  // halt, nop
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      valE_q      <= '0;
      cnd_q       <= 1'b0;
      ins_err_q   <= 1'b0;
      cc_q        <= CC_RESET;
    end else if (bus.in_valid) begin
      out_valid_q <= 1'b1;
      valE_q      <= valE_d;
      cnd_q       <= cnd_d;
      ins_err_q   <= ins_err_d;
      cc_q        <= cc_d;
    end else begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.valE      = valE_q;
  assign bus.cnd       = cnd_q;
  assign bus.ins_err   = ins_err_q;
  assign bus.zf        = cc_q[2];
  assign bus.sf        = cc_q[1];
  assign bus.of        = cc_q[0];

endmodule

// File: tb/tb_execute.sv
// Scoreboard bench for execute: directed vectors push expected results, a negedge monitor pops and compares.
// Latency: expects each issued instruction at the output one edge later.
// Backpressure: none exercised; in_valid is dropped only for idle/hold checks.
module tb_execute;
  logic clk;
  logic rst;

  execute_if bus ();

  execute #(.STACK_STEP(8), .CC_RESET(3'b100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] e;
    logic        c;
    logic        err;
    logic [2:0]  cc;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   vec_no  = 0;

  task automatic chk(input string nm, input logic [69:0] act, input logic [69:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: whenever the DUT presents a result, compare with the oldest expectation.
  always @(negedge clk) begin
    exp_t got;
    exp_t want;
    if (!rst && bus.out_valid) begin
      got = '{bus.valE, bus.cnd, bus.ins_err, {bus.zf, bus.sf, bus.of}};
      vec_no++;
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL result%0d: out_valid with nothing expected, got %h", vec_no, got);
      end else begin
        want = q.pop_front();
        if (got !== want) begin
          n_fail++;
          $display("FAIL result%0d: got valE=%h cnd=%b err=%b cc=%b expected valE=%h cnd=%b err=%b cc=%b",
                   vec_no, got.e, got.c, got.err, got.cc, want.e, want.c, want.err, want.cc);
        end
      end
    end
  end

  task automatic issue(input logic [3:0] ic, input logic [3:0] fn,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                       input logic [63:0] ee, input logic ec, input logic eerr,
                       input logic [2:0] ecc);
    exp_t x;
    bus.in_valid = 1'b1;
    bus.icode    = ic;
    bus.ifun     = fn;
    bus.valA     = a;
    bus.valB     = b;
    bus.valC     = c;
    x = '{ee, ec, eerr, ecc};
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.icode    = 4'h0;
    bus.ifun     = 4'h0;
    bus.valA     = '0;
    bus.valB     = '0;
    bus.valC     = '0;

    #3;
    chk("reset_state", {bus.out_valid, bus.valE, bus.cnd, bus.ins_err, bus.zf, bus.sf, bus.of},
        {1'b0, 64'd0, 1'b0, 1'b0, 3'b100});
    #4 rst = 1'b0;
    @(posedge clk);
    #1;

    // add overflow
    issue(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0,
          64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 3'b011);
    bus.in_valid = 1'b0;
    // async reset mid-cycle while out_valid is still high
    @(negedge clk);
    #2;
    chk("pre_reset_valid", {69'd0, bus.out_valid}, {69'd0, 1'b1});
    rst = 1'b1;
    #1;
    chk("async_reset", {bus.out_valid, bus.valE, bus.cnd, bus.ins_err, bus.zf, bus.sf, bus.of},
        {1'b0, 64'd0, 1'b0, 1'b0, 3'b100});
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    // sub to zero, then back-to-back je / jne
    issue(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 64'd0, 1'b0, 1'b0, 3'b100);
    issue(4'h7, 4'h3, 64'd0, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0, 3'b100);
    issue(4'h7, 4'h4, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 3'b100);
    // stack and address ops
    issue(4'h8, 4'h0, 64'd0, 64'h100, 64'd0, 64'hF8,  1'b0, 1'b0, 3'b100);
    issue(4'hB, 4'h0, 64'd0, 64'h100, 64'd0, 64'h108, 1'b0, 1'b0, 3'b100);
    issue(4'h5, 4'h0, 64'd0, 64'h20,  64'h8, 64'h28,  1'b0, 1'b0, 3'b100);
    // 3 - 5 = -2 gives CC {0,1,0}
    issue(4'h6, 4'h1, 64'd5, 64'd3, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 3'b010);
    issue(4'h2, 4'h1, 64'd7, 64'd0, 64'd0, 64'd7, 1'b1, 1'b0, 3'b010);  // cmovle
    issue(4'h7, 4'h2, 64'd0, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0, 3'b010);  // jl
    issue(4'h7, 4'h6, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 3'b010);  // jg
    issue(4'h7, 4'h5, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 3'b010);  // jge
    // and / xor
    issue(4'h6, 4'h2, 64'hF0, 64'hFF, 64'd0, 64'hF0, 1'b0, 1'b0, 3'b000);
    issue(4'h6, 4'h3, 64'h55, 64'h55, 64'd0, 64'd0, 1'b0, 1'b0, 3'b100);
    // illegal instructions: CC untouched, valE/cnd zero
    issue(4'h6, 4'h5, 64'd1, 64'd2, 64'd0, 64'd0, 1'b0, 1'b1, 3'b100);
    issue(4'h7, 4'h7, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b1, 3'b100);
    issue(4'hD, 4'h0, 64'd1, 64'd2, 64'd3, 64'd0, 1'b0, 1'b1, 3'b100);
    // sub overflow: MIN - 1
    issue(4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 64'd0,
          64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 3'b001);
    issue(4'h7, 4'h2, 64'd0, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0, 3'b001);  // jl on OF
    issue(4'h3, 4'h0, 64'd0, 64'd0, 64'h1234, 64'h1234, 1'b0, 1'b0, 3'b001);
    issue(4'h1, 4'h0, 64'd9, 64'd9, 64'd9, 64'd0, 1'b0, 1'b0, 3'b001);  // nop
    issue(4'h3, 4'h0, 64'd0, 64'd0, 64'hABCD, 64'hABCD, 1'b0, 1'b0, 3'b001);

    // idle: out_valid drops, everything else holds
    bus.in_valid = 1'b0;
    bus.icode    = 4'h6;
    bus.ifun     = 4'h0;
    bus.valA     = 64'd1;
    bus.valB     = 64'd1;
    @(posedge clk);
    #1;
    chk("idle_hold", {bus.out_valid, bus.valE, bus.cnd, bus.ins_err, bus.zf, bus.sf, bus.of},
        {1'b0, 64'hABCD, 1'b0, 1'b0, 3'b001});

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 70'(q.size()), 70'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
